// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, frame-buffer geometry and the
// control bundle that travels alongside each pixel through the read pipeline.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b0;

  localparam int SRC_W    = 320;
  localparam int FB_DEPTH = 76800;
  localparam int FB_AW    = 17;
  localparam int RD_LAT   = 2;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } vga_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus the raw sync/visible/frame-start qualifiers.
// Qualifiers are gated by enable so a parked raster emits nothing.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [HW-1:0]      hcnt,
  output vga_pkg::vga_ctl_t  ctl,
  output logic               frame_end,
  output logic               odd_line_end
);
  import vga_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last, v_vis;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);
  assign v_vis  = (vcnt_q < V_VIS);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    ctl.active = enable && (hcnt_q < H_VIS) && v_vis;
    ctl.hs     = enable && (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
    ctl.vs     = enable && (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
    ctl.fs     = enable && (hcnt_q == '0) && (vcnt_q == '0);
  end

  assign hcnt         = hcnt_q;
  assign frame_end    = h_last && v_last;
  assign odd_line_end = h_last && vcnt_q[0] && v_vis;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the 320x240 RGB444 frame buffer out to 640x480 VGA with 2x2 upscale.
// Control qualifiers are delayed to line up with BRAM read data.
module vga_frame_reader #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter int   SRC_W    = vga_pkg::SRC_W,
  parameter int   RD_LAT   = vga_pkg::RD_LAT,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic [vga_pkg::FB_AW-1:0] rd_addr,
  input  logic [11:0]               rd_data,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      blank,
  output logic                      frame_start
);
  import vga_pkg::*;

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

  logic [HW-1:0] hcnt;
  vga_ctl_t      ctl;
  logic          frame_end, odd_line_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .hcnt         (hcnt),
    .ctl          (ctl),
    .frame_end    (frame_end),
    .odd_line_end (odd_line_end)
  );

  logic [FB_AW-1:0] line_base_q, line_base_d;
  logic [FB_AW-1:0] rd_addr_q, rd_addr_d;

  // Each source row is shown on two screen lines, so the base steps after odd lines only.
  always_comb begin
    line_base_d = line_base_q;
    if (!enable || frame_end) begin
      line_base_d = '0;
    end else if (odd_line_end) begin
      line_base_d = line_base_q + FB_AW'(SRC_W);
    end
    rd_addr_d = ctl.active ? line_base_q + FB_AW'(hcnt >> 1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      line_base_q <= line_base_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign rd_addr = rd_addr_q;

  // Stage 0 pairs with the address register; the remaining RD_LAT stages cover the BRAM.
  genvar gi;
  generate
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_dly
      vga_ctl_t stg_in;
      vga_ctl_t stg_q;
      if (gi == 0) begin : g_head
        assign stg_in = ctl;
      end else begin : g_tail
        assign stg_in = g_dly[gi-1].stg_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_in;
      end
    end
  endgenerate

  vga_ctl_t    dl;
  logic [11:0] rgb_q;
  logic        blank_q, hs_q, vs_q, fs_q;

  assign dl = g_dly[RD_LAT].stg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      blank_q <= 1'b1;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= dl.active ? rd_data : 12'd0;
      blank_q <= ~dl.active;
      hs_q    <= dl.hs ^ ~SYNC_POL;
      vs_q    <= dl.vs ^ ~SYNC_POL;
      fs_q    <= dl.fs;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign blank       = blank_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Drives a full-size and a shrunken-timing reader with random enable/reset
// activity and compares every cycle against a raster-position model.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_n, enable;

  logic [16:0] rd_addr_a [2];
  logic [11:0] rd_data_a [2];
  logic [11:0] d1_a      [2];
  logic [3:0]  r_a [2], g_a [2], b_a [2];
  logic        hs_a [2], vs_a [2], blank_a [2], fs_a [2];

  vga_frame_reader dut_full (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .rd_addr (rd_addr_a[0]), .rd_data (rd_data_a[0]),
    .vga_r (r_a[0]), .vga_g (g_a[0]), .vga_b (b_a[0]),
    .vga_hs (hs_a[0]), .vga_vs (vs_a[0]), .blank (blank_a[0]),
    .frame_start (fs_a[0])
  );

  vga_frame_reader #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SRC_W    (8)
  ) dut_small (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .rd_addr (rd_addr_a[1]), .rd_data (rd_data_a[1]),
    .vga_r (r_a[1]), .vga_g (g_a[1]), .vga_b (b_a[1]),
    .vga_hs (hs_a[1]), .vga_vs (vs_a[1]), .blank (blank_a[1]),
    .frame_start (fs_a[1])
  );

  // Frame-buffer stand-in: two-clock read latency, data = addr[11:0].
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      d1_a[i]      <= rd_addr_a[i][11:0];
      rd_data_a[i] <= d1_a[i];
    end
  end

  int g_ht [2], g_vt [2], g_ha [2], g_va [2], g_sw [2];
  int g_hs0 [2], g_hs1 [2], g_vs0 [2], g_vs1 [2];

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [16:0] addr;
  } rec_t;

  // What the raster must be doing p enabled clocks after the scan (re)started.
  function automatic rec_t pix(int i, int p);
    rec_t r;
    int h, v;
    h = p % g_ht[i];
    v = (p / g_ht[i]) % g_vt[i];
    r.act  = (h < g_ha[i]) && (v < g_va[i]);
    r.hs   = (h >= g_hs0[i]) && (h <= g_hs1[i]);
    r.vs   = (v >= g_vs0[i]) && (v <= g_vs1[i]);
    r.fs   = (h == 0) && (v == 0);
    r.addr = r.act ? 17'((v / 2) * g_sw[i] + h / 2) : 17'd0;
    return r;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  rec_t hist [2][5];
  int   pos  [2];
  bit   lit_on = 1'b0;
  int   rel    = 0;

  always @(negedge clk) begin
    logic [32:0] act_v, exp_v;
    rec_t cur, e1, e4;
    for (int i = 0; i < 2; i++) begin
      act_v = {rd_addr_a[i], r_a[i], g_a[i], b_a[i], hs_a[i], vs_a[i], blank_a[i], fs_a[i]};
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) hist[i][k] = '0;
        pos[i] = 0;
        exp_v  = {17'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      end else begin
        cur = enable ? pix(i, pos[i]) : '0;
        for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = cur;
        e1 = hist[i][1];
        e4 = hist[i][4];
        exp_v = {e1.addr, (e4.act ? e4.addr[11:0] : 12'd0), ~e4.hs, ~e4.vs, ~e4.act, e4.fs};
        pos[i] = enable ? pos[i] + 1 : 0;
      end
      chk((i == 0) ? "model_full" : "model_small", {31'd0, act_v}, {31'd0, exp_v});
    end

    // Hand-computed anchors, counted in clocks from the first reset release.
    if (lit_on) begin
      if (rel == 0) begin
        chk("rel0_rd_addr", rd_addr_a[0], 0);
        chk("rel0_blank", blank_a[0], 1);
        chk("rel0_hs", hs_a[0], 1);
      end
      if (rel == 3) chk("fs_early", fs_a[0], 0);
      if (rel == 4) begin
        chk("fs_full_at4", fs_a[0], 1);
        chk("fs_small_at4", fs_a[1], 1);
        chk("blank_first_px", blank_a[0], 0);
        chk("rgb_first_px", {r_a[0], g_a[0], b_a[0]}, 12'h000);
      end
      if (rel == 5) chk("fs_one_clock", fs_a[0], 0);
      if (rel == 7) begin
        chk("rgb_px3_full", {r_a[0], g_a[0], b_a[0]}, 12'h001);
        chk("rgb_px3_small", {r_a[1], g_a[1], b_a[1]}, 12'h001);
      end
      if (rel == 49)   chk("small_line2_base", rd_addr_a[1], 8);
      if (rel == 136)  chk("small_last_addr", rd_addr_a[1], 23);
      if (rel == 171)  chk("small_vs_before", vs_a[1], 1);
      if (rel == 172)  chk("small_vs_start", vs_a[1], 0);
      if (rel == 219)  chk("small_vs_end", vs_a[1], 0);
      if (rel == 220)  chk("small_vs_after", vs_a[1], 1);
      if (rel == 265)  chk("small_wrap_addr0", rd_addr_a[1], 0);
      if (rel == 267)  chk("small_wrap_addr1", rd_addr_a[1], 1);
      if (rel == 640)  chk("line0_last_addr", rd_addr_a[0], 319);
      if (rel == 641)  chk("line0_hblank_addr", rd_addr_a[0], 0);
      if (rel == 643)  chk("px639_visible", blank_a[0], 0);
      if (rel == 644)  chk("px640_blank", blank_a[0], 1);
      if (rel == 659)  chk("hs_before", hs_a[0], 1);
      if (rel == 660)  chk("hs_start", hs_a[0], 0);
      if (rel == 755)  chk("hs_last", hs_a[0], 0);
      if (rel == 756)  chk("hs_after", hs_a[0], 1);
      if (rel == 804)  chk("line1_px0_blank", blank_a[0], 0);
      if (rel == 1460) chk("hs_line1", hs_a[0], 0);
      if (rel == 1611) chk("line2_px10_addr", rd_addr_a[0], 325);
      if (rel == 3201) chk("line4_base", rd_addr_a[0], 640);
      rel++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, act;
    rst_n  = 1'b0;
    enable = 1'b1;
    g_ha = '{640, 16};  g_va = '{480, 6};  g_sw = '{320, 8};
    g_ht = '{800, 24};  g_vt = '{525, 11};
    g_hs0 = '{656, 18}; g_hs1 = '{751, 20};
    g_vs0 = '{490, 7};  g_vs1 = '{491, 8};

    cyc(5);
    rst_n  = 1'b1;
    lit_on = 1'b1;
    $display("txn 0: reset released, enable high");
    cyc(5000);

    n = $urandom_range(0, 799);
    cyc(n);
    enable = 1'b0;
    cyc(50);
    enable = 1'b1;
    $display("txn 1: enable parked 50 clocks after %0d extra clocks", n);
    cyc(3000);

    n = $urandom_range(100, 700);
    cyc(n);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    $display("txn 2: reset pulsed 3 clocks after %0d extra clocks", n);
    cyc(4000);

    for (int t = 3; t < 33; t++) begin
      cyc($urandom_range(1, 400));
      act = $urandom_range(0, 3);
      n   = (act == 3) ? $urandom_range(1, 4) : $urandom_range(1, 30);
      if (act == 3) begin
        rst_n = 1'b0;
        cyc(n);
        rst_n = 1'b1;
        $display("txn %0d: reset pulse %0d clocks", t, n);
      end else begin
        enable = 1'b0;
        cyc(n);
        enable = 1'b1;
        $display("txn %0d: enable low %0d clocks", t, n);
      end
    end
    cyc(1200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream stage of the camera capture path. Scans out the 320x240, 12-bit RGB444 frame buffer that the capture stage fills, and drives a 640x480@60 VGA display.
- Each source pixel is shown as a 2x2 block on screen (2x upscale).
- Sits between the frame-buffer BRAM read port and the board VGA pins, in the 25 MHz pixel-clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SRC_W, 320, source frame width in pixels (one address per pixel)
RD_LAT, 2, BRAM read latency in clocks, from rd_addr to rd_data
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  pixel clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; low parks the raster
rd_addr  out  17  frame-buffer read address
rd_data  in  12  frame-buffer read data {R[3:0],G[3:0],B[3:0]}
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
blank  out  1  high outside the visible area
frame_start  out  1  one-clock pulse marking the first visible pixel of a frame

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n is low:
  - hcnt = 0, vcnt = 0, line_base = 0, rd_addr = 0
  - vga_r/g/b = 0, blank = 1, frame_start = 0
  - vga_hs and vga_vs at their inactive level (~SYNC_POL)
- Counters:
  - hcnt runs 0..799 (H_TOTAL) and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..524 (V_TOTAL), then wraps to 0.
- Sync windows, evaluated on the raw counters:
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hs_raw is asserted for hcnt in [656, 751]
  - vs_raw is asserted for vcnt in [490, 491]
- Address generation (no multiplier; registered, so rd_addr lags the counters by 1 clock):
  - rd_addr = line_base + (hcnt >> 1) when active, else 0.
  - line_base = 0 at vcnt = 0.
  - line_base increases by SRC_W at the end of every odd visible line (vcnt[0] = 1, hcnt = 799, vcnt < V_ACTIVE).
  - line_base returns to 0 on frame wrap.
  - Last visible address is 239*320 + 319 = 76799. rd_addr never exceeds 76799.
- Pipeline alignment:
  - active, hs_raw, vs_raw and the frame-start condition (hcnt = 0, vcnt = 0) pass through a delay line of RD_LAT+1 stages, so they align with rd_data.
  - The output registers add 1 more clock.
  - Total latency from counter state to pins is RD_LAT+2 clocks, identical for RGB, syncs, blank and frame_start.
- Output register:
  - RGB = rd_data fields when delayed active = 1, else 0.
  - blank = ~delayed active.
  - vga_hs = delayed hs_raw ^ ~SYNC_POL; vga_vs likewise.
- enable:
  - Sampled every clock.
  - When low: hcnt, vcnt and line_base are forced to 0 the next clock; the delay line flushes with inactive values; outputs become blank with syncs inactive within RD_LAT+2 clocks.
  - When enable rises again, scan restarts at pixel (0,0). frame_start fires RD_LAT+2 clocks later.
- Reset mid-frame: all state and outputs go to their reset values immediately, with no partial-line output afterwards.
- Simultaneous hcnt and vcnt wrap: line_base goes to 0. The frame-wrap reset of line_base takes precedence over the odd-line increment.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants (H_*/V_*, H_TOTAL = 800, V_TOTAL = 525)
  - sync polarity constant
  - FB_DEPTH = 76800 and FB_AW = 17, shared with the capture stage and the frame-buffer instance
- One sub-module, vga_timing_gen:
  - Contains hcnt/vcnt, hs_raw/vs_raw, active and frame-start detection.
  - Takes enable, clk and rst_n.
- vga_frame_reader keeps address generation, the delay line and the output register.

Test Plan:
- Reset held, then released with enable = 1 -> during reset, RGB = 0, blank = 1, hs = vs = 1, frame_start = 0. frame_start pulses exactly RD_LAT+2 = 4 clocks after release.
- BRAM model with RD_LAT = 2 returning data = addr[11:0], first line -> rd_addr sequence 0,0,1,1,...,319,319, then 0 during blanking. Pixel n on the pins equals n>>1, so there is no off-by-one between data and blank.
- Lines 0..3 -> line_base = 0, 0, 320, 320, and line 4 starts at 640. The last visible pixel of the frame reads address 76799, and the next frame starts again at 0.
- Sync timing on the pins -> hs low for 96 clocks starting 656 clocks after the line's first visible pixel, period 800. vs low for 2 lines (1600 clocks), period 525 lines. blank high for 160 clocks per line.
- enable dropped at line 100, pixel 300, then raised 50 clocks later -> outputs are blank with syncs inactive within 4 clocks, and the scan restarts at (0,0) with rd_addr = 0.
- rst_n pulsed low for 3 clocks mid-line 200 -> outputs take reset values asynchronously. After release, the sequence matches the first scenario.
